// File: rtl/dot_product_mac_pkg.sv
// Shared definitions for the dot-product MAC: state encoding, default
// geometry and the accumulator width rule.
package dot_product_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN    = 4;

  // Wide enough that LEN full-scale products can never wrap.
  function automatic int acc_width(input int data_w, input int len);
    return 2 * data_w + $clog2(len);
  endfunction

endpackage

// File: rtl/dot_product_mac_if.sv
// Element-in / result-out handshake bundle for the dot-product MAC.
interface dot_product_mac_if
  import dot_product_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = acc_width(DEF_DATA_W, DEF_LEN)
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/dot_product_mac_adder.sv
// Ripple-carry adder built from chained full_adder cells; carry-in is tied
// low and the final carry is exposed.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

module ripple_carry_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum,
  output logic         carry_out
);

  logic [W:0] carry;

  assign carry[0]  = 1'b0;
  assign carry_out = carry[W];

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .x    (x[i]),
      .y    (y[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/dot_product_mac.sv
// Sequential multiply-accumulate: sums LEN unsigned a*b products and hands
// the dot product downstream over a valid/ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_ACCUM  | accepting element pairs, accumulating products
// S_DONE   | result presented, waiting for out_ready; inputs stalled
module dot_product_mac
  import dot_product_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN    = DEF_LEN,
  parameter int ACC_W  = acc_width(DATA_W, LEN)
) (
  input  logic               clk,
  input  logic               rst,
  dot_product_mac_if.slave   bus
);

  localparam logic [0:0] S_ACCUM = ST_ACCUM;
  localparam logic [0:0] S_DONE  = ST_DONE;

  localparam int                CNT_W    = $clog2(LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LEN - 1);

  logic [0:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    result_q;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    sum;
  logic                carry_unused;
  logic                accept;

  assign prod     = bus.a * bus.b;
  assign prod_ext = ACC_W'(prod);

  ripple_carry_adder #(.W(ACC_W)) u_add (
    .x         (acc),
    .y         (prod_ext),
    .sum       (sum),
    .carry_out (carry_unused)
  );

  // Handshake outputs are gated by rst so nothing is offered during reset.
  assign bus.in_ready  = (state == S_ACCUM) && !rst;
  assign bus.out_valid = (state == S_DONE) && !rst;
  assign bus.result    = result_q;
  assign accept        = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_ACCUM;
      cnt      <= '0;
      acc      <= '0;
      result_q <= '0;
    end else if (state == S_ACCUM) begin
      if (accept) begin
        if (cnt == CNT_LAST) begin
          result_q <= sum;
          acc      <= '0;
          cnt      <= '0;
          state    <= S_DONE;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end else begin
      if (bus.out_ready) state <= S_ACCUM;
    end
  end

endmodule

// File: tb/tb_dot_product_mac.sv
// Self-checking bench for dot_product_mac (DATA_W=8, LEN=4): table vectors,
// random vectors against an arithmetic reference, and reset corner cases.
module tb_dot_product_mac;

  localparam int DATA_W = 8;
  localparam int LEN    = 4;
  localparam int ACC_W  = 18;

  typedef struct {
    logic [0:3][7:0] va;
    logic [0:3][7:0] vb;
    int              gap;
    int              hold;
    longint          exp;
    string           name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  dot_product_mac_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  dot_product_mac #(.DATA_W(DATA_W), .LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: the dot product is just the sum of element-wise products.
  function automatic longint ref_dot(input logic [0:3][7:0] va, input logic [0:3][7:0] vb);
    longint s = 0;
    for (int i = 0; i < LEN; i++) s += longint'(va[i]) * longint'(vb[i]);
    return s;
  endfunction

  // All driving and sampling happens on the falling edge.
  task automatic run_vector(input logic [0:3][7:0] va, input logic [0:3][7:0] vb,
                            input int gap, input int hold, input longint exp,
                            input string name);
    bus.out_ready = (hold == 0);
    for (int i = 0; i < LEN; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          bus.a = DATA_W'($urandom);
          bus.b = DATA_W'($urandom);
          @(negedge clk);
          check({name, " gap out_valid"}, longint'(bus.out_valid), 0);
        end
      end
      bus.in_valid = 1'b1;
      bus.a = va[i];
      bus.b = vb[i];
      check({name, " in_ready"}, longint'(bus.in_ready), 1);
      @(negedge clk);
      if (i < LEN - 1) check({name, " early out_valid"}, longint'(bus.out_valid), 0);
    end
    check({name, " out_valid"}, longint'(bus.out_valid), 1);
    check({name, " result"}, longint'(bus.result), exp);
    check({name, " in_ready in DONE"}, longint'(bus.in_ready), 0);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.a = DATA_W'($urandom);
      bus.b = DATA_W'($urandom);
      @(negedge clk);
      check({name, " held out_valid"}, longint'(bus.out_valid), 1);
      check({name, " held in_ready"}, longint'(bus.in_ready), 0);
      check({name, " held result"}, longint'(bus.result), exp);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check({name, " out_valid after handshake"}, longint'(bus.out_valid), 0);
    check({name, " result kept"}, longint'(bus.result), exp);
    check({name, " in_ready after handshake"}, longint'(bus.in_ready), 1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{va: '{8'd1, 8'd2, 8'd3, 8'd4}, vb: '{8'd5, 8'd6, 8'd7, 8'd8},
                gap: 0, hold: 0, exp: 70, name: "basic"};
    vecs[1] = '{va: '{8'd255, 8'd255, 8'd255, 8'd255}, vb: '{8'd255, 8'd255, 8'd255, 8'd255},
                gap: 0, hold: 0, exp: 260100, name: "max"};
    vecs[2] = '{va: '{8'd1, 8'd2, 8'd3, 8'd4}, vb: '{8'd5, 8'd6, 8'd7, 8'd8},
                gap: 2, hold: 3, exp: 70, name: "gaps_bp"};
    vecs[3] = '{va: '{8'd1, 8'd1, 8'd1, 8'd1}, vb: '{8'd2, 8'd2, 8'd2, 8'd2},
                gap: 0, hold: 0, exp: 8, name: "b2b_1"};
    vecs[4] = '{va: '{8'd3, 8'd0, 8'd0, 8'd3}, vb: '{8'd1, 8'd9, 8'd9, 8'd1},
                gap: 0, hold: 0, exp: 6, name: "b2b_2"};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset in_ready", longint'(bus.in_ready), 0);
    check("reset out_valid", longint'(bus.out_valid), 0);
    check("reset result", longint'(bus.result), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", longint'(bus.in_ready), 1);
    check("post-reset out_valid", longint'(bus.out_valid), 0);

    foreach (vecs[i])
      run_vector(vecs[i].va, vecs[i].vb, vecs[i].gap, vecs[i].hold, vecs[i].exp, vecs[i].name);

    for (int r = 0; r < 10; r++) begin
      logic [0:3][7:0] ra, rb;
      for (int i = 0; i < LEN; i++) begin
        ra[i] = 8'($urandom);
        rb[i] = 8'($urandom);
      end
      run_vector(ra, rb, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 ref_dot(ra, rb), $sformatf("rand%0d", r));
    end

    // Reset mid-vector: the partial 10*10+10*10 must vanish.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 8'd10;
      bus.b = 8'd10;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid-reset out_valid", longint'(bus.out_valid), 0);
    check("mid-reset in_ready", longint'(bus.in_ready), 0);
    check("mid-reset result", longint'(bus.result), 0);
    rst = 1'b0;
    @(negedge clk);
    check("after mid-reset out_valid", longint'(bus.out_valid), 0);
    check("after mid-reset in_ready", longint'(bus.in_ready), 1);
    run_vector(vecs[0].va, vecs[0].vb, 0, 0, 70, "after_mid_reset");

    // Reset while holding a finished result.
    bus.out_ready = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 8'd1;
      bus.b = 8'd2;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("done-reset pre out_valid", longint'(bus.out_valid), 1);
    check("done-reset pre result", longint'(bus.result), 8);
    rst = 1'b1;
    @(negedge clk);
    check("done-reset out_valid", longint'(bus.out_valid), 0);
    check("done-reset result", longint'(bus.result), 0);
    rst = 1'b0;
    @(negedge clk);
    check("done-reset release in_ready", longint'(bus.in_ready), 1);
    check("done-reset release out_valid", longint'(bus.out_valid), 0);
    run_vector(vecs[3].va, vecs[3].vb, 1, 1, 8, "after_done_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dot_product_mac.md
# dot_product_mac

Sequential multiply-accumulate stage for the dot-product datapath. Accepts one element pair (a, b) per cycle over a valid/ready handshake, forms the unsigned product, and accumulates LEN products into a single dot-product result. The result is presented downstream on a second valid/ready handshake. The accumulator adder is a ripple-carry chain built from the existing `full_adder` cell, so this block is the direct consumer of that cell.

## Interface
- `DATA_W`, default 8: width of each unsigned input element.
- `LEN`, default 4: elements per vector, ≥ 2.
- `ACC_W`, default 2*DATA_W + $clog2(LEN): accumulator/result width; guarantees no overflow.
- `clk`  input  1  single clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  element pair present on `a`, `b`.
- `in_ready`  output  1  block can accept an element this cycle.
- `a`  input  DATA_W  unsigned element of vector A.
- `b`  input  DATA_W  unsigned element of vector B.
- `out_valid`  output  1  `result` holds a completed dot product.
- `out_ready`  input  1  downstream accepts `result`.
- `result`  output  ACC_W  unsigned sum of LEN products.

## Operation
- States: ACCUM, DONE. Reset state is ACCUM.
- ACCUM:
  - `in_ready`=1.
  - On accept (`in_valid && in_ready`): acc <= acc + a*b and cnt <= cnt+1.
  - If the accept occurs with cnt == LEN-1: `result` <= acc + a*b, acc <= 0, cnt <= 0, go to DONE.
  - `in_valid`=0 cycles (gaps) leave acc and cnt unchanged.
- DONE:
  - `in_ready`=0, `out_valid`=1, `result` stable.
  - On `out_ready`=1: return to ACCUM next cycle with `out_valid`=0.
  - `out_ready`=0 holds DONE indefinitely; no inputs are accepted.
- Arithmetic: unsigned only. Product is 2*DATA_W bits, zero-extended to ACC_W before the add. The carry-out of the adder is always 0 by construction; do not check or use it.
- `a`/`b` are ignored when no accept occurs; X on them then must not reach acc.
- `result` keeps its value after the out handshake until the next vector completes.

## Timing
- Reset values while `rst`=1 and the cycle after: state=ACCUM, acc=0, cnt=0, `out_valid`=0, `result`=0. `in_ready` is forced 0 while `rst`=1 and is 1 from the first cycle with `rst`=0.
- Reset mid-vector discards the partial sum; the next accepted element starts a new vector.
- Reset in DONE drops `out_valid` and discards the result.
- Latency: `out_valid` rises the cycle after the LEN-th accept.
- Minimum period per vector: LEN+1 cycles (LEN accepts + 1 DONE cycle with `out_ready`=1).
- The first element of the next vector can be accepted the cycle after the out handshake.
- The adder is combinational within one cycle (ripple over ACC_W bits). No pipelining is required at the target clock.

## Structure
- Shared package `dot_product_pkg`:
  - state enum encoding (ACCUM, DONE);
  - default DATA_W and LEN localparams;
  - ACC_W derivation function.
- Sub-module `ripple_carry_adder` (parameter W): W chained `full_adder` instances, carry_in tied 0, carry_out exposed. Instantiate once with W=ACC_W for acc + product.
- Product uses the `*` operator. A separate multiplier block is not required.

## Test plan
All scenarios use DATA_W=8, LEN=4.
- Basic: a={1,2,3,4}, b={5,6,7,8} back-to-back, `out_ready`=1 → `result`=70, `out_valid` for exactly 1 cycle, one cycle after the 4th accept.
- Max values: all a=b=255 → `result`=260100 (fits 18 bits), no wrap.
- Gaps and back-pressure: same vector as Basic with `in_valid` low 2 cycles between elements, `out_ready` low 3 cycles in DONE → `result`=70 held stable, `in_ready`=0 throughout DONE, accepted on the 4th cycle.
- Back-to-back vectors: {1,1,1,1}·{2,2,2,2} then {3,0,0,3}·{1,9,9,1} → results 8 then 6; second vector's first element accepted the cycle after the first out handshake; acc correctly cleared.
- Reset mid-operation: accept 2 elements (10,10), assert `rst` 1 cycle, then send the Basic vector → `result`=70 with no contamination; `out_valid`=0 during and after reset.
- Reset in DONE: complete a vector, hold `out_ready`=0, assert `rst` → `out_valid`=0 next cycle, `result`=0, `in_ready`=1 after release.
